// File: rtl/local_memory_fifo_ctrl_if.sv
// Stream + memory-port bundle for the local memory FIFO controller.
// slave: controller side; master: producer/consumer/memory side.
interface local_memory_fifo_ctrl_if #(
  parameter int W_WIDTH = 16,
  parameter int W_ADDR  = 10
);
  logic               flush;
  logic [W_WIDTH-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [W_WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [W_WIDTH-1:0] mem_data;
  logic [W_ADDR-1:0]  mem_wraddress;
  logic               mem_wren;
  logic [W_ADDR-1:0]  mem_rdaddress;
  logic [W_WIDTH-1:0] mem_q;
  logic               full;
  logic               empty;
  logic [W_ADDR+1:0]  level;

  modport slave (
    input  flush, in_data, in_valid,
    input  out_ready, mem_q,
    output in_ready, out_data, out_valid,
    output mem_data, mem_wraddress, mem_wren,
    output mem_rdaddress,
    output full, empty, level
  );

  modport master (
    output flush, in_data, in_valid,
    output out_ready, mem_q,
    input  in_ready, out_data, out_valid,
    input  mem_data, mem_wraddress, mem_wren,
    input  mem_rdaddress,
    input  full, empty, level
  );
endinterface

// File: rtl/local_memory_fifo_ctrl.sv
// FIFO controller around a dual-port memory with a 2-entry output skid.
// Ports: MCLK, RST (async high), bus (slave: streams, mem ports, status).
module local_memory_fifo_ctrl #(
  parameter int W_WIDTH = 16,
  parameter int W_ADDR  = 10
) (
  input  logic MCLK,
  input  logic RST,
  local_memory_fifo_ctrl_if.slave bus
);

  localparam int LW = W_ADDR + 2;
  localparam logic [W_ADDR:0] DEPTH_C =
    {1'b1, {W_ADDR{1'b0}}};

  logic [W_ADDR-1:0]  wr_ptr;
  logic [W_ADDR-1:0]  rd_ptr;
  logic [W_ADDR:0]    mem_cnt;
  logic               inflight;
  logic [1:0]         skid_cnt;
  logic [W_WIDTH-1:0] skid0;
  logic [W_WIDTH-1:0] skid1;

  logic          full_i;
  logic          in_rdy;
  logic          wr_acc;
  logic          rd_iss;
  logic          pop;
  logic          push;
  logic [1:0]    occ;
  logic [LW-1:0] lvl;

  // A pop in the same cycle frees a slot, so a read may
  // be issued against it; this keeps 1 word/cycle.
  always_comb begin
    full_i = (mem_cnt == DEPTH_C);
    in_rdy = !full_i && !bus.flush;
    wr_acc = bus.in_valid && in_rdy;
    pop    = (skid_cnt != 2'd0) && bus.out_ready;
    push   = inflight;
    occ    = skid_cnt + {1'b0, inflight};
    rd_iss = (mem_cnt != '0) && !bus.flush &&
             ((occ < 2'd2) || (pop && occ == 2'd2));
    lvl    = LW'(mem_cnt) + LW'(inflight) +
             LW'(skid_cnt);
  end

  assign bus.in_ready      = in_rdy;
  assign bus.mem_wren      = wr_acc;
  assign bus.mem_wraddress = wr_ptr;
  assign bus.mem_data      = bus.in_data;
  assign bus.mem_rdaddress = rd_ptr;
  assign bus.out_valid     = (skid_cnt != 2'd0);
  assign bus.out_data      = skid0;
  assign bus.full          = full_i;
  assign bus.level         = lvl;
  assign bus.empty         = (lvl == '0);

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + W_ADDR'(1);
      if (rd_iss) rd_ptr <= rd_ptr + W_ADDR'(1);
      unique case (1'b1)
        wr_acc && !rd_iss:
          mem_cnt <= mem_cnt + (W_ADDR+1)'(1);
        rd_iss && !wr_acc:
          mem_cnt <= mem_cnt - (W_ADDR+1)'(1);
        default: ;
      endcase
      inflight <= rd_iss;
    end
  end

  // skid0 is always the head; skid1 only holds a
  // second word when two are buffered.
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else if (bus.flush) begin
      skid_cnt <= 2'd0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          if (skid_cnt == 2'd2) begin
            skid0 <= skid1;
            skid1 <= bus.mem_q;
          end else begin
            skid0 <= bus.mem_q;
          end
        end
        push && !pop: begin
          if (skid_cnt == 2'd0) skid0 <= bus.mem_q;
          else                  skid1 <= bus.mem_q;
          skid_cnt <= skid_cnt + 2'd1;
        end
        pop && !push: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
